bb_xfer_sched: RTL
==================

Name: bb_xfer_sched

Overview:
- Schedules transfers from two bus-bridge requesters (local master port and remote bridge port) onto one shared system-bus master interface.
- Arbitrates between the requesters and widens each 13-bit bridge address to the 16-bit bus address map.
- Issues one transfer at a time, waits for completion and returns read data to the winning requester.
- Sits between the bridge front-ends and the bus master adapter.

Parameters:
- BB_ADDR_WIDTH, 13, bridge-side address width; MSB selects slave bank.
- BUS_ADDR_WIDTH, 16, system-bus address width.
- BUS_MEM_ADDR_WIDTH, 13, slave-local memory address width; bank bit lands here.
- DATA_WIDTH, 8, data width.
- TIMEOUT_CYCLES, 255, max cycles in WAIT before abort; must be ≥1.

Ports:
- clk input 1 system clock
- rst input 1 asynchronous reset, active-high
- req_valid input 2 per-requester request (bit0 local, bit1 remote)
- req_ready output 2 per-requester accept strobe
- req_addr input 2*BB_ADDR_WIDTH packed bridge addresses, requester n at slice n
- req_we input 2 1=write, 0=read
- req_wdata input 2*DATA_WIDTH packed write data
- rsp_valid output 2 one-cycle completion pulse to owning requester
- rsp_err output 1 completion was a timeout; valid with rsp_valid
- rsp_rdata output DATA_WIDTH read data, valid with rsp_valid
- bus_req output 1 bus ownership request
- bus_grant input 1 bus ownership granted
- bus_valid output 1 transfer strobe, held until bus_done
- bus_addr output BUS_ADDR_WIDTH converted address
- bus_we output 1 write enable
- bus_wdata output DATA_WIDTH write data
- bus_rdata input DATA_WIDTH read data, sampled on bus_done
- bus_done input 1 slave completion
- busy output 1 high whenever state ≠ IDLE

Behaviour:
- Reset: state=IDLE, all outputs 0, rr pointer=0 (local preferred first). Async assert, sync release.
- Address conversion (registered at accept):
  - bus_addr[BUS_MEM_ADDR_WIDTH-2:0] = req_addr[BB_ADDR_WIDTH-2:0], zero-extended.
  - bus_addr[BUS_MEM_ADDR_WIDTH] = req_addr MSB.
  - Bits above BUS_MEM_ADDR_WIDTH are 0; bit BUS_MEM_ADDR_WIDTH-1 is 0 when widths are equal.
- States:
  - IDLE: if any req_valid, pick winner by round-robin: pointer's requester wins if valid, else the other. Pulse req_ready[winner] for one cycle. Latch addr/we/wdata/owner. Rr pointer moves to the loser. Next state is REQ.
  - REQ: bus_req=1; on bus_grant go to WAIT with bus_valid=1 next cycle.
  - WAIT: bus_req, bus_valid and transfer fields held stable. Increment timer.
    - On bus_done: capture bus_rdata, go to RESP.
    - If timer reaches TIMEOUT_CYCLES: go to RESP with err.
    - bus_done wins if it coincides with the final timer cycle.
  - RESP: rsp_valid[owner]=1 one cycle, rsp_err per outcome, rsp_rdata held until next RESP. Drop bus_req/bus_valid. Go to IDLE.
- Latency, no contention, grant immediate: req_ready at cycle 0, bus_valid at cycle 2, rsp_valid the cycle after bus_done.
- Requester valid while not in IDLE: no ready; stays pending.
- Write rsp_rdata is 0.
- bus_grant dropped during WAIT: ignored; transfer continues.
- bus_done outside WAIT: ignored.
- Reset mid-transfer: immediate return to IDLE; no rsp issued.

Optional Feature:
- BB_SCHED_FIXED_PRIO_EN:
  - Defined: requester 1 (remote) always wins simultaneous requests; rr pointer removed.
  - Undefined: round-robin as above.

Decomposition:
- Package bb_sched_pkg: state encoding (IDLE, REQ, WAIT, RESP), requester index constants LOCAL=0, REMOTE=1, default widths.
- One combinational sub-module bb_addr_widen performs the bank-bit address mapping; instantiate at the latch input.

Test Plan:
- Local read, addr 13'h1005, bus_done after 3 cycles with rdata 8'hA5 → bus_addr 16'h2005, bus_we=0, rsp_valid=2'b01, rsp_rdata=A5, rsp_err=0.
- Remote write, addr 13'h0FFF, wdata 8'h3C → bus_addr 16'h0FFF, bus_we=1, bus_wdata=3C, rsp_valid=2'b10.
- Both valid continuously for four transfers → grant order local, remote, local, remote; with BB_SCHED_FIXED_PRIO_EN → remote every time.
- bus_grant delayed 5 cycles → bus_valid stays 0 and bus_req stays 1 until grant; no req_ready to the second requester meanwhile.
- No bus_done, TIMEOUT_CYCLES=4 → rsp_err=1 and rsp_valid after 4 WAIT cycles; next request proceeds normally.
- rst asserted during WAIT → all outputs 0 within the same cycle; no rsp pulse; a fresh request after release completes.

Source files
------------

// File: rtl/bb_sched_pkg.sv
// bb_sched_pkg -- shared definitions for the bus-bridge transfer scheduler.
//   state_t       : scheduler FSM encoding (IDLE, REQ, WAIT, RESP)
//   LOCAL/REMOTE  : requester indices into the packed per-requester ports
//   *_DEF         : default widths and timeout used by the modules below
package bb_sched_pkg;

  localparam int BB_ADDR_WIDTH_DEF      = 13;
  localparam int BUS_ADDR_WIDTH_DEF     = 16;
  localparam int BUS_MEM_ADDR_WIDTH_DEF = 13;
  localparam int DATA_WIDTH_DEF         = 8;
  localparam int TIMEOUT_CYCLES_DEF     = 255;

  localparam logic LOCAL  = 1'b0;
  localparam logic REMOTE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/bb_addr_widen.sv
// bb_addr_widen -- combinational bridge-to-bus address mapping.
//   bb_addr  : bridge address; MSB selects the slave bank
//   bus_addr : system-bus address. The low bridge bits land in the bottom
//              BUS_MEM_ADDR_WIDTH-1 bits, the bank bit lands at bit
//              BUS_MEM_ADDR_WIDTH, and every other bit is zero.
module bb_addr_widen
  import bb_sched_pkg::*;
#(
  parameter int BB_ADDR_WIDTH      = BB_ADDR_WIDTH_DEF,
  parameter int BUS_ADDR_WIDTH     = BUS_ADDR_WIDTH_DEF,
  parameter int BUS_MEM_ADDR_WIDTH = BUS_MEM_ADDR_WIDTH_DEF
) (
  input  logic [BB_ADDR_WIDTH-1:0]  bb_addr,
  output logic [BUS_ADDR_WIDTH-1:0] bus_addr
);

  localparam int LOW_W = BUS_MEM_ADDR_WIDTH - 1;

  always_comb begin
    // NOTE: assigning a default before any partial/conditional assignment
    // keeps always_comb from inferring a latch.
    bus_addr = '0;
    bus_addr[LOW_W-1:0]         = LOW_W'(bb_addr[BB_ADDR_WIDTH-2:0]);
    bus_addr[BUS_MEM_ADDR_WIDTH] = bb_addr[BB_ADDR_WIDTH-1];
  end

endmodule

// File: rtl/bb_xfer_sched.sv
// bb_xfer_sched -- arbitrates the local and remote bridge requesters onto a
// single system-bus master, one transfer at a time.
//   req_*   : per-requester request channel (bit/slice 0 local, 1 remote);
//             req_ready is a one-cycle accept strobe in IDLE
//   rsp_*   : one-cycle completion pulse to the owner, with timeout flag and
//             read data (read data is held until the next completion)
//   bus_*   : bus master interface: bus_req until completion, bus_valid and
//             transfer fields held through WAIT until bus_done
//   busy    : scheduler is not IDLE
// Build option: define BB_SCHED_FIXED_PRIO_EN to give the remote requester
// fixed priority; otherwise arbitration is round-robin.
module bb_xfer_sched
  import bb_sched_pkg::*;
#(
  parameter int BB_ADDR_WIDTH      = BB_ADDR_WIDTH_DEF,
  parameter int BUS_ADDR_WIDTH     = BUS_ADDR_WIDTH_DEF,
  parameter int BUS_MEM_ADDR_WIDTH = BUS_MEM_ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH         = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES     = TIMEOUT_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [2*BB_ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]                 req_we,
  input  logic [2*DATA_WIDTH-1:0]    req_wdata,
  output logic [1:0]                 rsp_valid,
  output logic                       rsp_err,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       bus_req,
  input  logic                       bus_grant,
  output logic                       bus_valid,
  output logic [BUS_ADDR_WIDTH-1:0]  bus_addr,
  output logic                       bus_we,
  output logic [DATA_WIDTH-1:0]      bus_wdata,
  input  logic [DATA_WIDTH-1:0]      bus_rdata,
  input  logic                       bus_done,
  output logic                       busy
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t                    state, state_nx;
  logic                      winner;
  logic                      accept;
  logic [BB_ADDR_WIDTH-1:0]  sel_addr;
  logic [BUS_ADDR_WIDTH-1:0] sel_bus_addr;
  logic                      owner_q;
  logic                      err_q;
  logic [TIMER_W-1:0]        timer_q;
  logic [BUS_ADDR_WIDTH-1:0] addr_q;
  logic                      we_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH-1:0]     rdata_q;

`ifdef BB_SCHED_FIXED_PRIO_EN
  assign winner = req_valid[REMOTE] ? REMOTE : LOCAL;
`else
  // rr_ptr names the requester that wins a tie; it always moves to the loser.
  logic rr_ptr;
  assign winner = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
`endif

  assign sel_addr = winner ? req_addr[2*BB_ADDR_WIDTH-1:BB_ADDR_WIDTH]
                           : req_addr[BB_ADDR_WIDTH-1:0];

  bb_addr_widen #(
    .BB_ADDR_WIDTH      (BB_ADDR_WIDTH),
    .BUS_ADDR_WIDTH     (BUS_ADDR_WIDTH),
    .BUS_MEM_ADDR_WIDTH (BUS_MEM_ADDR_WIDTH)
  ) u_widen (
    .bb_addr  (sel_addr),
    .bus_addr (sel_bus_addr)
  );

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: if (|req_valid) begin
        accept   = 1'b1;
        state_nx = REQ;
      end
      REQ:  if (bus_grant) state_nx = WAIT;
      // bus_done is checked together with the last timer cycle, so a
      // completion on that cycle is reported as success.
      WAIT: if (bus_done || timer_q == TIMER_LAST) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner_q <= LOCAL;
      err_q   <= 1'b0;
      timer_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifndef BB_SCHED_FIXED_PRIO_EN
      rr_ptr  <= LOCAL;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        owner_q <= winner;
        addr_q  <= sel_bus_addr;
        we_q    <= req_we[winner];
        wdata_q <= winner ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                          : req_wdata[DATA_WIDTH-1:0];
`ifndef BB_SCHED_FIXED_PRIO_EN
        rr_ptr  <= ~winner;
`endif
      end
      if (state == REQ)
        timer_q <= '0;
      else if (state == WAIT)
        timer_q <= timer_q + TIMER_W'(1);
      if (state == WAIT && state_nx == RESP) begin
        err_q   <= ~bus_done;
        rdata_q <= (bus_done && !we_q) ? bus_rdata : '0;
      end
    end
  end

  // req_ready is the only output decoded straight from inputs; it is masked
  // during reset so that every output reads zero while rst is high.
  assign req_ready = rst ? 2'b00 : {accept & winner, accept & ~winner};
  assign rsp_valid = (state == RESP) ? {owner_q, ~owner_q} : 2'b00;
  assign rsp_err   = (state == RESP) & err_q;
  assign rsp_rdata = rdata_q;
  assign bus_req   = (state == REQ) || (state == WAIT);
  assign bus_valid = (state == WAIT);
  assign bus_addr  = addr_q;
  assign bus_we    = we_q;
  assign bus_wdata = wdata_q;
  assign busy      = (state != IDLE);

endmodule
